// File: rtl/boa_cache_pkg.sv
// rtl/boa_cache_pkg.sv - shared types and geometry helpers for boa_cache
package boa_cache_pkg;

   // Line-transfer engine states
   typedef enum logic [2:0] {
      XF_IDLE,
      XF_WB_RD,
      XF_WB_WR,
      XF_FILL,
      XF_DONE
   } boa_xfer_state_t;

   // Width of the word-in-line index for a given line size in words
   function automatic int boa_lswidth(input int line_size);
      return $clog2(line_size);
   endfunction

   // Byte-address bit where the line address starts (word index + byte-in-word)
   function automatic int boa_agrain(input int line_size);
      return boa_lswidth(line_size) + 2;
   endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// rtl/boa_mem_bus.sv - external memory bus used by boa_cache
interface boa_mem_bus #(
   parameter int alen = 24
);
   logic            re;
   logic [3:0]      we;
   logic [alen-1:2] addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            ready;

   modport CPU (output re, we, addr, wdata, input rdata, ready);
   modport MEM (input re, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/boa_cache_line_xfer.sv
// rtl/boa_cache_line_xfer.sv - write-back / refill line transfer engine for boa_cache
module boa_cache_line_xfer
   import boa_cache_pkg::*;
#(
   parameter int alen      = 24,
   parameter int line_size = 16
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        cmd_valid,
   output logic                                        cmd_ready,
   input  logic                                        cmd_wb,
   input  logic [alen-boa_agrain(line_size)-1:0]       cmd_wb_addr,
   input  logic                                        cmd_fill,
   input  logic [alen-boa_agrain(line_size)-1:0]       cmd_fill_addr,
   output logic                                        done,
   output logic [boa_lswidth(line_size)-1:0]           ram_raddr,
   input  logic [31:0]                                 ram_rdata,
   output logic                                        ram_we,
   output logic [boa_lswidth(line_size)-1:0]           ram_waddr,
   output logic [31:0]                                 ram_wdata,
   boa_mem_bus.CPU                                     xm_bus
);

   localparam int lswidth = boa_lswidth(line_size);
   localparam int agrain  = boa_agrain(line_size);
   localparam logic [lswidth-1:0] last_idx = lswidth'(line_size - 1);

   boa_xfer_state_t           state;
   logic [lswidth-1:0]        idx;
   logic                      fill_q;
   logic [alen-agrain-1:0]    wb_addr_q;
   logic [alen-agrain-1:0]    fill_addr_q;
   logic                      at_last;

   assign at_last = (idx == last_idx);

   // Sequencer: command latch, per-word stepping and word index counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= XF_IDLE;
         idx         <= '0;
         fill_q      <= 1'b0;
         wb_addr_q   <= '0;
         fill_addr_q <= '0;
      end else begin
         case (state)
            XF_IDLE: begin
               if (cmd_valid) begin
                  fill_q      <= cmd_fill;
                  wb_addr_q   <= cmd_wb_addr;
                  fill_addr_q <= cmd_fill_addr;
                  idx         <= '0;
                  if (cmd_wb)
                     state <= XF_WB_RD;
                  else if (cmd_fill)
                     state <= XF_FILL;
                  else
                     state <= XF_DONE;
               end
            end
            XF_WB_RD: begin
               // RAM read of word idx is in flight; its data is valid next cycle
               state <= XF_WB_WR;
            end
            XF_WB_WR: begin
               if (xm_bus.ready) begin
                  if (at_last) begin
                     idx   <= '0;
                     state <= fill_q ? XF_FILL : XF_DONE;
                  end else begin
                     idx   <= idx + lswidth'(1);
                     state <= XF_WB_RD;
                  end
               end
            end
            XF_FILL: begin
               if (xm_bus.ready) begin
                  if (at_last) begin
                     idx   <= '0;
                     state <= XF_DONE;
                  end else begin
                     idx   <= idx + lswidth'(1);
                  end
               end
            end
            XF_DONE: begin
               state <= XF_IDLE;
            end
            default: begin
               state <= XF_IDLE;
            end
         endcase
      end
   end

   // Handshake and status outputs follow the state directly so reset clears them at once
   assign cmd_ready = (state == XF_IDLE);
   assign done      = (state == XF_DONE);

   // RAM read index stays on idx through WB_WR so the bus write data holds during wait states
   assign ram_raddr = idx;

   // Refill words go straight from the bus into the RAM on the accepting edge
   assign ram_we    = (state == XF_FILL) && xm_bus.ready;
   assign ram_waddr = idx;
   assign ram_wdata = xm_bus.rdata;

   // Bus request: write during WB_WR, read during FILL, never both
   assign xm_bus.re    = (state == XF_FILL);
   assign xm_bus.we    = (state == XF_WB_WR) ? 4'hF : 4'h0;
   assign xm_bus.wdata = ram_rdata;

   // Word address is the latched line address with idx as the low bits, so it never leaves the line
   always_comb begin
      xm_bus.addr = '0;
      if (state == XF_WB_WR)
         xm_bus.addr = {wb_addr_q, idx};
      else if (state == XF_FILL)
         xm_bus.addr = {fill_addr_q, idx};
   end

endmodule
